seg7_scan_ctrl: RTL

Parametrised memory-mapped seven-segment display controller, the successor to the fixed four-digit LED device on the bridge's DEV2 port. It drives 1–8 multiplexed digits from one shared segment bus. It adds PWM brightness, per-digit blanking and leading-zero suppression. A frame-synchronous shadow copy of the display state prevents tearing. Instances sit behind the bridge like the counter and switch devices and use the same Addr/WD/Wr/BE/RD register protocol.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_hex_decode.sv | 9 +
 rtl/seg7_scan_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: register map, CTRL field positions and hex segment table for seg7_scan_ctrl
package seg7_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_DPR = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_BRIGHT = 2'd3;
  localparam int CTRL_EN = 0;
  localparam int CTRL_LZS = 1;
  localparam int CTRL_BLANK = 8;
  localparam logic [4:0] BRIGHT_MAX = 5'd16;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: hex nibble to active-high {G,F,E,D,C,B,A} segment pattern
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);
  assign pat = hex7(nib);
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: memory-mapped multiplexed seven-segment controller with PWM, blanking, LZS and frame shadow
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV = 50000,
  parameter bit SEG_ACTIVE_LOW = 1,
  parameter bit SEL_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [1:0]            Addr,
  input  logic [31:0]           WD,
  input  logic                  Wr,
  input  logic [3:0]            BE,
  output logic [31:0]           RD,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] sel
);
  localparam int N = NUM_DIGITS;
  localparam int S = SCAN_DIV / 16;
  localparam int SW = S > 1 ? $clog2(S) : 1;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  logic [4*N-1:0] data, data_n, data_s;
  logic [N-1:0] dpr, dpr_n, dpr_s, blank, blank_n, blank_s;
  logic en, en_n, lzs, lzs_n, lzs_s;
  logic [4:0] bright, bright_n, bright_s;
  logic [SW-1:0] sub;
  logic [3:0] phase, nib;
  logic [IW-1:0] idx;
  logic [31:0] mask;
  logic [N:0] hi_nz;
  logic [6:0] pat;
  logic wr_d, wr_p, wr_c, wr_b, slot_end, wrap, lit;

  assign mask = lane_mask(BE);
  assign wr_d = Wr && Addr == ADDR_DATA;
  assign wr_p = Wr && Addr == ADDR_DPR;
  assign wr_c = Wr && Addr == ADDR_CTRL;
  assign wr_b = Wr && Addr == ADDR_BRIGHT;

  always_comb begin
    data_n = wr_d ? (data & ~mask[4*N-1:0]) | (WD[4*N-1:0] & mask[4*N-1:0]) : data;
    dpr_n = wr_p ? (dpr & ~mask[N-1:0]) | (WD[N-1:0] & mask[N-1:0]) : dpr;
    blank_n = wr_c ? (blank & ~mask[CTRL_BLANK +: N]) | (WD[CTRL_BLANK +: N] & mask[CTRL_BLANK +: N]) : blank;
    en_n = wr_c && BE[0] ? WD[CTRL_EN] : en;
    lzs_n = wr_c && BE[0] ? WD[CTRL_LZS] : lzs;
    bright_n = wr_b && BE[0] ? (WD[4:0] > BRIGHT_MAX ? BRIGHT_MAX : WD[4:0]) : bright;
  end

  assign RD = Addr == ADDR_DATA ? 32'(data) :
              Addr == ADDR_DPR  ? 32'(dpr) :
              Addr == ADDR_CTRL ? (32'(en) << CTRL_EN) | (32'(lzs) << CTRL_LZS) | (32'(blank) << CTRL_BLANK) :
                                  32'(bright);

  always_comb begin
    hi_nz = '0;
    for (int i = N - 1; i >= 0; i--) hi_nz[i] = hi_nz[i+1] | (|data_s[4*i +: 4]);
  end

  assign slot_end = sub == SW'(S - 1) && phase == 4'hF;
  assign wrap = en && slot_end && idx == IW'(N - 1);
  assign nib = data_s[4*idx +: 4];
  assign lit = en && en_n && ({1'b0, phase} < bright_s) && !blank_s[idx] && !(lzs_s && idx != '0 && !hi_nz[idx]);

  seg7_hex_decode u_dec (
    .nib(nib),
    .pat(pat)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      {data, dpr, blank, en, lzs, bright} <= {{(4*N){1'b0}}, {N{1'b0}}, {N{1'b0}}, 1'b1, 1'b0, BRIGHT_MAX};
      {data_s, dpr_s, blank_s, lzs_s, bright_s} <= {{(4*N){1'b0}}, {N{1'b0}}, {N{1'b0}}, 1'b0, BRIGHT_MAX};
      sub <= '0;
      phase <= '0;
      idx <= '0;
      seg <= {8{SEG_ACTIVE_LOW}};
      sel <= {N{SEL_ACTIVE_LOW}};
    end else begin
      {data, dpr, blank, en, lzs, bright} <= {data_n, dpr_n, blank_n, en_n, lzs_n, bright_n};
      if (en_n && !en) {data_s, dpr_s, blank_s, lzs_s, bright_s} <= {data_n, dpr_n, blank_n, lzs_n, bright_n};
      else if (wrap) {data_s, dpr_s, blank_s, lzs_s, bright_s} <= {data, dpr, blank, lzs, bright};
      if (!en) begin
        sub <= '0;
        phase <= '0;
        idx <= '0;
      end else begin
        sub <= sub == SW'(S - 1) ? '0 : sub + 1'b1;
        phase <= sub == SW'(S - 1) ? phase + 1'b1 : phase;
        idx <= slot_end ? (idx == IW'(N - 1) ? '0 : idx + 1'b1) : idx;
      end
      seg <= (lit ? {dpr_s[idx], pat} : 8'h00) ^ {8{SEG_ACTIVE_LOW}};
      sel <= (lit ? N'(1) << idx : {N{1'b0}}) ^ {N{SEL_ACTIVE_LOW}};
    end
  end
endmodule
